// File: rtl/traffic_phase_ctl.sv
// N-phase traffic signal controller: one-hot GREEN/YELLOW/ALLRED/FLASH FSM with
// Tick-driven timers, demand-based phase skipping and rest-on-green.
module traffic_phase_ctl #(
    parameter int NUM_PHASES   = 4,
    parameter int CNT_W        = 8,
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 3,
    parameter int ALLRED_TICKS = 1,
    parameter int PH_W         = $clog2(NUM_PHASES)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Tick,
    input  logic [NUM_PHASES-1:0] Req,
    input  logic                  Flash,
    output logic [NUM_PHASES-1:0] Red,
    output logic [NUM_PHASES-1:0] Yellow,
    output logic [NUM_PHASES-1:0] Green,
    output logic [PH_W-1:0]       Phase,
    output logic [3:0]            State_cnt,
    output logic                  Phase_start,
    output logic [CNT_W-1:0]      Remain
);

    localparam logic [3:0] S_GREEN  = 4'b0001;
    localparam logic [3:0] S_YELLOW = 4'b0010;
    localparam logic [3:0] S_ALLRED = 4'b0100;
    localparam logic [3:0] S_FLASH  = 4'b1000;

    localparam logic [CNT_W-1:0] T_G = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] T_Y = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] T_A = CNT_W'(ALLRED_TICKS - 1);

    logic [3:0]            r_state, w_nstate;
    logic [PH_W-1:0]       r_phase, w_nphase, w_search, w_idx;
    logic [CNT_W-1:0]      r_timer, w_ntimer;
    logic                  r_tog, w_ntog, r_pstart, w_exp;
    logic [NUM_PHASES-1:0] w_ph_oh;

    assign w_exp   = Tick && (r_timer == '0);
    assign w_ph_oh = NUM_PHASES'(1) << r_phase;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= S_ALLRED;
            r_phase  <= PH_W'(NUM_PHASES - 1);
            r_timer  <= T_A;
            r_tog    <= 1'b0;
            r_pstart <= 1'b0;
        end else begin
            r_state  <= w_nstate;
            r_phase  <= w_nphase;
            r_timer  <= w_ntimer;
            r_tog    <= w_ntog;
            r_pstart <= (w_nstate == S_GREEN) && (r_state != S_GREEN);
        end
    end

    // Round-robin from Phase+1; iterating farthest-first lets the nearest requester win.
    always_comb begin
        w_idx    = '0;
        w_search = PH_W'((int'(r_phase) + 1) % NUM_PHASES);
        for (int k = NUM_PHASES; k >= 1; k--) begin
            w_idx = PH_W'((int'(r_phase) + k) % NUM_PHASES);
            if (Req[w_idx]) w_search = w_idx;
        end
    end

    always_comb begin
        w_nstate = r_state;
        w_nphase = r_phase;
        w_ntog   = r_tog;
        w_ntimer = (Tick && r_timer != '0) ? r_timer - 1'b1 : r_timer;
        if (!(r_state inside {S_GREEN, S_YELLOW, S_ALLRED, S_FLASH})) begin
            w_nstate = S_ALLRED;
            w_ntimer = T_A;
        end else if (Flash && r_state != S_FLASH) begin
            w_nstate = S_FLASH;
            w_ntimer = '0;
            w_ntog   = 1'b0;
        end else begin
            case (r_state)
                S_GREEN: if (w_exp && |(Req & ~w_ph_oh)) begin
                    w_nstate = S_YELLOW;
                    w_ntimer = T_Y;
                end
                S_YELLOW: if (w_exp) begin
                    w_nstate = S_ALLRED;
                    w_ntimer = T_A;
                end
                S_ALLRED: if (w_exp) begin
                    w_nstate = S_GREEN;
                    w_ntimer = T_G;
                    w_nphase = w_search;
                end
                S_FLASH: if (!Flash) begin
                    w_nstate = S_ALLRED;
                    w_ntimer = T_A;
                end else if (Tick) begin
                    w_ntog = ~r_tog;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        Green  = '0;
        Yellow = '0;
        Red    = '1;
        case (r_state)
            S_GREEN:  begin Green  = w_ph_oh; Red = ~w_ph_oh; end
            S_YELLOW: begin Yellow = w_ph_oh; Red = ~w_ph_oh; end
            S_FLASH:  begin Yellow = {NUM_PHASES{r_tog}}; Red = '0; end
            default:  ;
        endcase
    end

    assign Phase       = r_phase;
    assign State_cnt   = r_state;
    assign Phase_start = r_pstart;
    assign Remain      = r_timer;

endmodule

// File: tb/tb_traffic_phase_ctl.sv
// Scoreboard bench for traffic_phase_ctl: a behavioural model queues the expected
// outputs for each driven cycle; they are popped and compared after the clock edge.
module tb_traffic_phase_ctl;

    localparam int N  = 4;
    localparam int CW = 8;
    localparam int GT = 4;
    localparam int YT = 2;
    localparam int AT = 1;

    logic          Clk = 1'b0;
    logic          Reset, Tick, Flash;
    logic [N-1:0]  Req;
    logic [N-1:0]  Red, Yellow, Green;
    logic [1:0]    Phase;
    logic [3:0]    State_cnt;
    logic          Phase_start;
    logic [CW-1:0] Remain;

    traffic_phase_ctl #(
        .NUM_PHASES(N), .CNT_W(CW), .GREEN_TICKS(GT), .YELLOW_TICKS(YT), .ALLRED_TICKS(AT)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Tick(Tick), .Req(Req), .Flash(Flash),
        .Red(Red), .Yellow(Yellow), .Green(Green), .Phase(Phase),
        .State_cnt(State_cnt), .Phase_start(Phase_start), .Remain(Remain)
    );

    always #5 Clk = ~Clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] sb_q[$];

    // model: state as State_cnt encoding (1 G, 2 Y, 4 AR, 8 FL)
    int m_st = 4, m_ph = N - 1, m_tmr = AT - 1, m_tog = 0, m_ps = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_vec();
        logic [N-1:0] r, y, g;
        for (int i = 0; i < N; i++) begin
            g[i] = (m_st == 1) && (i == m_ph);
            y[i] = ((m_st == 2) && (i == m_ph)) || ((m_st == 8) && (m_tog != 0));
            r[i] = (m_st == 4) || (((m_st == 1) || (m_st == 2)) && (i != m_ph));
        end
        return {5'b0, 4'(m_st), 2'(m_ph), r, y, g, 1'(m_ps), (m_st == 8) ? 8'h0 : 8'(m_tmr)};
    endfunction

    function automatic logic [31:0] obs_vec();
        return {5'b0, State_cnt, Phase, Red, Yellow, Green, Phase_start,
                (State_cnt == 4'b1000) ? 8'h0 : Remain};
    endfunction

    task automatic m_step(input logic t, input logic [N-1:0] rq, input logic fl, input logic rs);
        int  prev = m_st;
        bit  ex   = t && (m_tmr == 0);
        int  base;
        if (rs) begin
            m_st = 4; m_ph = N - 1; m_tmr = AT - 1; m_tog = 0;
        end else if (fl && m_st != 8) begin
            m_st = 8; m_tog = 0;
        end else begin
            case (m_st)
                8: if (!fl) begin m_st = 4; m_tmr = AT - 1; end
                   else if (t) m_tog = (m_tog == 0) ? 1 : 0;
                1: if (ex && ((rq & ~(4'b0001 << m_ph)) != 0)) begin m_st = 2; m_tmr = YT - 1; end
                   else if (t && m_tmr > 0) m_tmr--;
                2: if (ex) begin m_st = 4; m_tmr = AT - 1; end
                   else if (t && m_tmr > 0) m_tmr--;
                default: if (ex) begin
                    base = m_ph;
                    m_ph = (base + 1) % N;
                    for (int k = 1; k <= N; k++)
                        if (rq[(base + k) % N]) begin m_ph = (base + k) % N; break; end
                    m_st = 1; m_tmr = GT - 1;
                end else if (t && m_tmr > 0) m_tmr--;
            endcase
        end
        m_ps = (!rs && m_st == 1 && prev != 1) ? 1 : 0;
    endtask

    task automatic cyc(input logic t, input logic [N-1:0] rq, input logic fl, input logic rs);
        Tick = t; Req = rq; Flash = fl; Reset = rs;
        m_step(t, rq, fl, rs);
        sb_q.push_back(m_vec());
        @(posedge Clk); #1;
        chk("sb", obs_vec(), sb_q.pop_front());
    endtask

    initial begin
        int n, ny;
        logic [N-1:0] exp_y;
        Reset = 1'b1; Tick = 1'b0; Req = '0; Flash = 1'b0;

        cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("rst_state", State_cnt, 4'b0100);
        chk("rst_phase", Phase, 3);
        chk("rst_red", Red, 4'b1111);
        chk("rst_yg", {Yellow, Green}, 0);
        chk("rst_ps", Phase_start, 0);

        // idle start: one all-red cycle then rest on phase 0
        cyc(1, 0, 0, 0);
        chk("first_green", Green, 4'b0001);
        chk("first_ps", Phase_start, 1);
        repeat (10) cyc(1, 0, 0, 0);
        chk("rest_state", State_cnt, 4'b0001);
        chk("rest_remain", Remain, 0);
        chk("rest_ps", Phase_start, 0);

        // skip phases 1,2 to reach 3
        n = 0; ny = 0;
        while (!(m_st == 1 && m_ph == 3) && n < 20) begin
            cyc(1, 4'b1000, 0, 0); n++;
            if (Yellow == 4'b0001) ny++;
        end
        chk("skip_cycles", n, 4);
        chk("skip_yellow", ny, YT);
        chk("skip_phase", Phase, 3);
        chk("skip_green", Green, 4'b1000);

        // green minimum length, then drop request in yellow -> wrap fallback
        n = 0;
        while (m_st != 2 && n < 20) begin cyc(1, 4'b0001, 0, 0); n++; end
        chk("green_len", n, GT);
        n = 0;
        while (m_st != 1 && n < 20) begin cyc(1, 4'b0000, 0, 0); n++; end
        chk("fallback_phase", Phase, 0);
        chk("fallback_green", Green, 4'b0001);

        // flash mode mid-green
        repeat (2) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        chk("flash_state", State_cnt, 4'b1000);
        chk("flash_rg", {Red, Green}, 0);
        chk("flash_y0", Yellow, 0);
        exp_y = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            exp_y = ~exp_y;
            cyc(1, 0, 1, 0);
            chk("flash_tog", Yellow, exp_y);
        end
        cyc(1, 4'b0010, 0, 0);
        chk("unflash_ar", State_cnt, 4'b0100);
        cyc(1, 4'b0010, 0, 0);
        chk("unflash_phase", Phase, 1);
        chk("unflash_ps", Phase_start, 1);

        // reset in second yellow cycle, with Flash also high
        n = 0;
        while (!(m_st == 2 && m_tmr == 0) && n < 20) begin cyc(1, 4'b1000, 0, 0); n++; end
        chk("pre_rst_y", State_cnt, 4'b0010);
        cyc(1, 4'b1000, 1, 1);
        chk("mid_rst_state", State_cnt, 4'b0100);
        chk("mid_rst_phase", Phase, 3);
        chk("mid_rst_red", Red, 4'b1111);

        // slow tick: yellow spans YT*3 clocks
        for (int i = 0; i < 20; i++) cyc((i % 3) == 0, 4'b0001, 0, 0);
        ny = 0;
        for (int i = 0; i < 40; i++) begin
            cyc((i % 3) == 0, 4'b1000, 0, 0);
            if (State_cnt == 4'b0010) ny++;
        end
        chk("slow_yellow", ny, 3 * YT);
        chk("slow_phase", Phase, 3);

        // random soak against the model
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 1)), 4'($urandom), $urandom_range(0, 15) == 0,
                $urandom_range(0, 63) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_phase_ctl.md
# traffic_phase_ctl

Parametrised N-phase traffic signal controller, the successor to the fixed two-way NS/EW controller. It drives per-phase Red/Yellow/Green lamps with built-in duration timers, so external Done counters are no longer needed. It adds demand-driven phase skipping, rest-on-green, an all-red clearance interval and a flashing-yellow maintenance mode. It sits between the time-base prescaler (which supplies `Tick`) and the lamp driver/display logic.

## Interface
- `NUM_PHASES`, 4, number of approaches/phases; legal range 2..8.
- `CNT_W`, 8, timer width; must hold max(*_TICKS)-1.
- `GREEN_TICKS`, 20, minimum green duration in Ticks; must be ≥1.
- `YELLOW_TICKS`, 3, yellow duration in Ticks; must be ≥1.
- `ALLRED_TICKS`, 1, all-red clearance in Ticks; must be ≥1.
- `PH_W`, derived as clog2(NUM_PHASES), phase index width.

Ports:
- `Clk`  in  1  single clock; all state is updated on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Tick`  in  1  one-cycle time-base enable; all timers count Ticks, not clocks.
- `Req`  in  NUM_PHASES  level demand per phase (detector/pushbutton).
- `Flash`  in  1  level; maintenance flashing-yellow mode request.
- `Red`, `Yellow`, `Green`  out  NUM_PHASES each  lamp drives, bit i = phase i.
- `Phase`  out  PH_W  index of the active (or last active) phase.
- `State_cnt`  out  4  one-hot state: GREEN=0001, YELLOW=0010, ALLRED=0100, FLASH=1000.
- `Phase_start`  out  1  one-cycle pulse in the first cycle of each GREEN.
- `Remain`  out  CNT_W  current timer value.

## Operation
- Registers: state (one-hot), `Phase`, timer, flash toggle. Lamp outputs are pure decodes of these registers, with no combinational path from any input.
- Lamps:
  - GREEN: `Green[Phase]`=1.
  - YELLOW: `Yellow[Phase]`=1.
  - In GREEN and YELLOW, every other bit of `Red` is 1.
  - ALLRED: `Red` all 1s.
  - FLASH: `Red`=`Green`=0 and `Yellow` = all bits equal to the flash toggle.
- Timer: loaded with TICKS-1 of the target state on every state entry. It decrements on `Tick` when nonzero. The timer expires when `Tick` is high and timer==0.
- GREEN→YELLOW: on expiry, if `Req & ~onehot(Phase)` ≠ 0. Otherwise the block rests on green: it stays in GREEN with the timer held at 0 and leaves on the first later Tick where another phase requests.
- YELLOW→ALLRED: on expiry.
- ALLRED→GREEN: on expiry.
  - `Phase` ← the first index with `Req` set, searching round-robin from Phase+1 with wrap (the current Phase is the last candidate).
  - If `Req`==0, `Phase` ← Phase+1 mod NUM_PHASES.
  - `Phase_start` pulses in the first GREEN cycle.
- Flash: `Flash`=1 in any non-FLASH state forces FLASH on the next edge.
  - Entry clears the toggle to 0 (`Yellow`=0 on the first FLASH cycle).
  - The toggle inverts on every `Tick`.
  - `Flash`=0 while in FLASH → ALLRED with the ALLRED timer loaded. `Phase` is retained, so the search resumes from Phase+1.
- Priority: `Reset` > `Flash` > timer transitions.
- Illegal (non-one-hot) state → ALLRED on the next edge.

## Timing
- Reset values: state ALLRED (`State_cnt`=0100), `Phase`=NUM_PHASES-1, timer=ALLRED_TICKS-1, flash toggle=0.
  - Therefore `Red`=all 1s, `Yellow`=0, `Green`=0, `Phase_start`=0.
  - The first green goes to the lowest requesting phase, or phase 0 if `Req`==0.
- Reset asserted mid-operation takes effect at the next edge regardless of Tick or state.
- Transitions happen on the edge following the cycle in which the expiry condition is true. Outputs change in that same edge's cycle (one-clock latency from the Tick cycle).
- Duration of each state:
  - YELLOW lasts exactly YELLOW_TICKS Ticks.
  - ALLRED lasts exactly ALLRED_TICKS Ticks.
  - GREEN lasts at least GREEN_TICKS Ticks.
- `Req` is sampled only at the GREEN expiry decision and at the ALLRED expiry search. A request that drops during YELLOW/ALLRED is not served and the fallback rule applies.
- `Flash` is sampled every cycle; it has 1-cycle latency to enter FLASH and 1-cycle latency to leave it.

## Test plan
Common configuration: NUM_PHASES=4, GREEN=4, YELLOW=2, ALLRED=1 Ticks, `Tick` high every cycle unless stated.

- Reset then `Req`=0: one ALLRED cycle (`Red`=1111), then GREEN `Phase`=0 with `Green`=0001 and `Phase_start` pulsing once. Rests in GREEN indefinitely with `Remain`=0.
- In GREEN phase 0, set `Req`=1000:
  - GREEN runs 4 cycles after entry (`Remain` 3,2,1,0).
  - YELLOW runs 2 cycles with `Yellow`=0001.
  - ALLRED runs 1 cycle.
  - Then GREEN `Phase`=3 with `Green`=1000; phases 1 and 2 are skipped.
- In GREEN phase 3, set `Req`=0001 and drop it during YELLOW: ALLRED falls back to Phase+1 and wraps to `Phase`=0.
- `Flash`=1 mid-GREEN:
  - Next cycle `State_cnt`=1000, `Green`=`Red`=0000, `Yellow` alternating 0000/1111 every cycle.
  - Deassert: ALLRED for 1 Tick, then GREEN on the next requesting phase.
- `Reset` asserted in the second YELLOW cycle: next cycle `State_cnt`=0100, `Phase`=3, `Red`=1111. `Flash`=1 together with `Reset` still yields the reset state.
- `Tick` every 3rd cycle: YELLOW spans 6 clocks, and `Remain` changes only on Tick cycles.
